// File: rtl/pwm_ramp_sched.sv
// Per-channel duty ramp scheduler: on each PWM cycle end, walks every channel and
// steps its duty toward target. Optional done_irq_o under PWM_RAMP_SCHED_DONE_IRQ_EN.

module pwm_ramp_sched_lane #(
    parameter int DutyDw = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  logic [DutyDw-1:0] wr_target_i,
    input  logic [DutyDw-1:0] wr_step_i,
    input  logic              wr_en_i,
    input  logic              upd_i,
    input  logic [DutyDw-1:0] upd_duty_i,
    output logic [DutyDw-1:0] duty_o,
    output logic [DutyDw-1:0] target_o,
    output logic [DutyDw-1:0] step_o,
    output logic              en_o,
    output logic              settled_o
);

    logic [DutyDw-1:0] duty_q, duty_d;
    logic [DutyDw-1:0] target_q, target_d;
    logic [DutyDw-1:0] step_q, step_d;
    logic              en_q, en_d;

    // Config writes only happen in IDLE and updates only in SWEEP, so they never collide.
    always_comb begin
        target_d = target_q;
        step_d   = step_q;
        en_d     = en_q;
        duty_d   = duty_q;
        if (wr_i) begin
            target_d = wr_target_i;
            step_d   = wr_step_i;
            en_d     = wr_en_i;
        end
        if (upd_i) begin
            duty_d = upd_duty_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= '0;
            en_q     <= 1'b0;
        end else begin
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            en_q     <= en_d;
        end
    end

    assign duty_o    = duty_q;
    assign target_o  = target_q;
    assign step_o    = step_q;
    assign en_o      = en_q;
    assign settled_o = (duty_q == target_q);

endmodule

module pwm_ramp_sched #(
    parameter int NChannels = 6,
    parameter int DutyDw    = 16,
    parameter int ChIdxW    = $clog2(NChannels)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cycle_end_i,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    input  logic [ChIdxW-1:0]           cfg_chan_i,
    input  logic [DutyDw-1:0]           cfg_target_i,
    input  logic [DutyDw-1:0]           cfg_step_i,
    input  logic                        cfg_en_i,
    output logic [NChannels*DutyDw-1:0] duty_o,
    output logic [NChannels-1:0]        settled_o,
    output logic                        busy_o,
`ifdef PWM_RAMP_SCHED_DONE_IRQ_EN
    output logic                        done_irq_o,
`endif
    output logic                        overrun_o
);

    typedef enum logic {IDLE, SWEEP} state_e;

    localparam logic [ChIdxW:0]   NumCh   = (ChIdxW+1)'(NChannels);
    localparam logic [ChIdxW-1:0] LastIdx = ChIdxW'(NChannels - 1);

    state_e            state_q, state_d;
    logic [ChIdxW-1:0] idx_q, idx_d;
    logic              pend_q, pend_d;
    logic              overrun_q, overrun_d;

    logic [NChannels-1:0][DutyDw-1:0] duty_a, target_a, step_a;
    logic [NChannels-1:0]             en_a, settled_a, wr_a, upd_a;

    logic              cfg_hs, chan_ok, sweeping, last;
    logic [DutyDw-1:0] sel_duty, sel_target, sel_step, new_duty;
    logic              sel_en, up;
    logic [DutyDw:0]   diff;

    assign sweeping = (state_q == SWEEP);
    assign last     = (idx_q == LastIdx);
    assign cfg_hs   = cfg_valid_i & (state_q == IDLE);
    assign chan_ok  = ({1'b0, cfg_chan_i} < NumCh);

    for (genvar i = 0; i < NChannels; i++) begin : g_lane
        assign wr_a[i]  = cfg_hs & chan_ok & (cfg_chan_i == ChIdxW'(i));
        assign upd_a[i] = sweeping & (idx_q == ChIdxW'(i));

        pwm_ramp_sched_lane #(.DutyDw(DutyDw)) u_lane (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .wr_i        (wr_a[i]),
            .wr_target_i (cfg_target_i),
            .wr_step_i   (cfg_step_i),
            .wr_en_i     (cfg_en_i),
            .upd_i       (upd_a[i]),
            .upd_duty_i  (new_duty),
            .duty_o      (duty_a[i]),
            .target_o    (target_a[i]),
            .step_o      (step_a[i]),
            .en_o        (en_a[i]),
            .settled_o   (settled_a[i])
        );
    end

    assign sel_duty   = duty_a[idx_q];
    assign sel_target = target_a[idx_q];
    assign sel_step   = step_a[idx_q];
    assign sel_en     = en_a[idx_q];

    // One shared step datapath; the extra difference bit keeps the compare unsigned-safe.
    always_comb begin
        up       = (sel_target > sel_duty);
        diff     = up ? ({1'b0, sel_target} - {1'b0, sel_duty})
                      : ({1'b0, sel_duty} - {1'b0, sel_target});
        new_duty = sel_duty;
        if (sel_en && (sel_step != '0)) begin
            if (diff <= {1'b0, sel_step}) begin
                new_duty = sel_target;
            end else if (up) begin
                new_duty = sel_duty + sel_step;
            end else begin
                new_duty = sel_duty - sel_step;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cycle_end_i || pend_q) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            SWEEP: begin
                if (cycle_end_i) begin
                    if (pend_q) overrun_d = 1'b1;
                    else        pend_d    = 1'b1;
                end
                if (last) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef PWM_RAMP_SCHED_DONE_IRQ_EN
    logic changed_q, changed_d;
    logic done_chk_q, done_chk_d;
    logic chg_now;

    // done_chk_q marks the first IDLE clock after a sweep that moved an enabled channel.
    assign chg_now = sweeping & sel_en & (new_duty != sel_duty);

    always_comb begin
        changed_d  = changed_q;
        done_chk_d = 1'b0;
        if (state_q == IDLE) begin
            changed_d = 1'b0;
        end else begin
            changed_d = changed_q | chg_now;
            if (last) done_chk_d = changed_q | chg_now;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            changed_q  <= 1'b0;
            done_chk_q <= 1'b0;
        end else begin
            changed_q  <= changed_d;
            done_chk_q <= done_chk_d;
        end
    end

    assign done_irq_o = done_chk_q & (&(settled_a | ~en_a));
`endif

    assign duty_o      = duty_a;
    assign settled_o   = settled_a;
    assign cfg_ready_o = (state_q == IDLE);
    assign busy_o      = sweeping;
    assign overrun_o   = overrun_q;

endmodule

// File: doc/pwm_ramp_sched.md
Name: pwm_ramp_sched

Overview:
- Per-channel duty-cycle ramp scheduler that feeds the PWM core's duty inputs.
- On each PWM pulse-cycle boundary it walks all channels in turn. Each enabled channel's duty moves one programmed step toward its programmed target, saturating at the target.
- Software or firmware-side logic programs target, step and enable per channel through a valid/ready config port. The port is shared with the sweep engine and is only open while the engine is idle.

Parameters:
- NChannels, 6, number of PWM channels scheduled.
- DutyDw, 16, width of duty, target and step values.
- ChIdxW, $clog2(NChannels), width of the channel index (derived; do not override).

Ports:
- clk_i  input  1  block clock.
- rst_ni  input  1  asynchronous active-low reset.
- cycle_end_i  input  1  single-cycle pulse from the PWM core at the end of each pulse cycle.
- cfg_valid_i  input  1  config request.
- cfg_ready_o  output  1  config accepted when high together with cfg_valid_i.
- cfg_chan_i  input  ChIdxW  target channel of the config write.
- cfg_target_i  input  DutyDw  ramp target duty.
- cfg_step_i  input  DutyDw  per-cycle ramp increment.
- cfg_en_i  input  1  ramp enable for the channel.
- duty_o  output  NChannels*DutyDw  registered current duty; channel i is at bits [i*DutyDw +: DutyDw].
- settled_o  output  NChannels  bit i high when duty i equals target i.
- busy_o  output  1  high while the FSM is in SWEEP.
- overrun_o  output  1  single-cycle pulse when a cycle_end_i is dropped.

Behaviour:
- Reset state:
  - All duty, target, step and en registers are 0; state is IDLE; sweep index is 0; pending flag is 0.
  - Outputs: duty_o = 0, settled_o = all ones, busy_o = 0, cfg_ready_o = 1, overrun_o = 0.
- FSM states: IDLE and SWEEP.
- cfg_ready_o = (state == IDLE). busy_o = (state == SWEEP).
- IDLE:
  - A handshake (cfg_valid_i & cfg_ready_o) writes target, step and en for cfg_chan_i on that clock edge.
  - If cfg_chan_i >= NChannels, the write is accepted and discarded.
  - cycle_end_i, or a set pending flag, moves the FSM to SWEEP with index 0 and clears pending.
  - When a handshake and cycle_end_i coincide, the config is written first, and the sweep that follows uses the new values.
- SWEEP: one channel is processed per clock, at index idx.
  - If en=0 or step=0, duty is unchanged.
  - Otherwise, if |target - duty| <= step, duty becomes target.
  - Otherwise duty becomes duty + step when target > duty, and duty - step when target < duty.
  - All comparisons are unsigned and use a DutyDw+1 bit difference. The result never wraps because it saturates at the target.
  - When idx == NChannels-1, the FSM returns to IDLE. A full sweep takes exactly NChannels clocks.
- Latency: the new duty for channel i appears on duty_o one clock after idx == i.
- settled_o is combinational from the duty and target registers.
- cycle_end_i during SWEEP:
  - If pending is clear, pending is set, and a new sweep starts on the clock after returning to IDLE. cfg_ready_o is high for that single IDLE clock.
  - If pending is already set, the event is dropped and overrun_o pulses for one cycle.
- A config write that changes the target of a channel part-way through a ramp takes effect on the next sweep. duty is never reset by a config write.
- Asserting reset mid-sweep returns every register to its reset value on the next evaluation; no partial state survives.

Optional Feature:
- Macro: PWM_RAMP_SCHED_DONE_IRQ_EN.
- With the macro defined:
  - Adds output done_irq_o (1 bit), reset value 0.
  - done_irq_o pulses for one clock on the IDLE-entry cycle after a sweep in which at least one enabled channel changed duty and, at the end of that sweep, every enabled channel is settled.
- Without the macro: the port is absent, and no change-tracking logic is generated.

Test Plan:
- Reset release -> duty_o = 0, settled_o = 6'b111111, cfg_ready_o = 1, busy_o = 0.
- Channel 2 programmed with target=100, step=30, en=1, then 4 cycle_end_i pulses spaced 20 clocks apart -> duty[2] reads 30, 60, 90, 100. settled_o[2] rises after the 4th sweep. Other channels stay at 0.
- Channel 0 at duty 100, retargeted to 10 with step 40 -> duty[0] reads 60, 20, 10.
- cycle_end_i pulsed on the 2nd and 4th clock of a sweep -> the 2nd pulse sets pending and a back-to-back sweep starts after one IDLE clock. The 4th pulse is dropped with a single overrun_o pulse.
- cfg_valid_i held during SWEEP with chan=1 -> no write occurs until the IDLE clock. A write with chan=7 (NChannels=6) is accepted and discarded. cfg_valid_i and cycle_end_i in the same IDLE clock -> the sweep uses the new values.
- With PWM_RAMP_SCHED_DONE_IRQ_EN defined, channels 0 and 3 enabled with targets 50 and 20 and step 25 -> done_irq_o pulses once, after the 2nd sweep. No pulse occurs on later sweeps with no change.
